// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and
// address constants.
package instruction_fetch_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO with flush; the head entry is presented directly from
// storage and reads as zero when the FIFO is empty.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// buffering, and redirect with draining of stale in-flight responses.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  input  logic        if_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] outstanding, buf_count;
  logic [CNT_W:0]   credit_used;
  logic             req_fire, resp_fire, ob_push, ob_pop;
  logic             pcq_full, pcq_empty, ob_full, ob_empty;
  logic [31:0]      pcq_head;
  logic [63:0]      ob_head;
  logic             unused_sigs;

  // The in-flight pc queue occupancy doubles as the outstanding-request count.
  fetch_buffer #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (resp_fire),
    .pop_data  (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (outstanding)
  );

  fetch_buffer #(.WIDTH(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (ob_push),
    .push_data ({pcq_head, imem_rdata}),
    .pop       (ob_pop),
    .pop_data  (ob_head),
    .full      (ob_full),
    .empty     (ob_empty),
    .count     (buf_count)
  );

  assign credit_used = {1'b0, buf_count} + {1'b0, outstanding};
  assign imem_req    = !reset && (state_q == ST_RUN) && !redirect &&
                       (credit_used < (CNT_W + 1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign req_fire    = imem_req && imem_ready;

  // A response in the redirect cycle still retires its request but is dropped.
  assign resp_fire = imem_rvalid && !pcq_empty && (state_q == ST_RUN);
  assign ob_push   = resp_fire && !redirect;
  assign ob_pop    = !ob_empty && if_ready && !redirect;

  assign if_valid       = !ob_empty;
  assign if_pc          = ob_head[63:32];
  assign if_instruction = ob_head[31:0];

  assign unused_sigs = ^{redirect_pc[1:0], pcq_full, ob_full};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    state_d    = state_q;
    if (redirect)      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    else if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          drop_d  = outstanding - CNT_W'(resp_fire);
          state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid && drop_q != '0) drop_d = drop_q - CNT_W'(1);
        if (drop_d == '0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a queue-based reference model and
// a simple in-order memory that can be stalled.
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_ready, imem_rvalid, redirect, if_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instruction;
  logic        hi_req, hi_valid;
  logic [31:0] hi_addr, hi_pc, hi_instr;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_pc(if_pc), .if_instruction(if_instruction), .if_ready(if_ready)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_hi (
    .clk(clk), .reset(reset), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(hi_valid),
    .if_pc(hi_pc), .if_instruction(hi_instr), .if_ready(if_ready)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  bit resp_en = 1'b0;
  bit mem_acc = 1'b0;
  logic [31:0] mem_acc_addr;
  logic [31:0] pending[$];
  logic [31:0] addr_log[$], hi_log[$], pc_log[$], ins_log[$];

  // reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_inflight[$];
  logic [63:0] m_obuf[$];
  int          m_drop;
  bit          m_drain;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 3) ^ a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hXXXX_XXXX;
  endfunction

  function automatic bit exp_req();
    return !reset && !m_drain && !redirect &&
           (m_inflight.size() + m_obuf.size() < DEPTH);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // memory: answers in request order, one word per cycle when enabled
  always @(negedge clk) begin
    #1;
    if (resp_en && pending.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pending[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // compare process and handshake logging
  always @(negedge clk) begin
    #3;
    mem_acc = 1'b0;
    if (started) begin
      check("imem_req", imem_req, exp_req());
      check("imem_addr", imem_addr, m_fpc);
      check("if_valid", if_valid, m_obuf.size() > 0);
      check("if_pc", if_pc, (m_obuf.size() > 0) ? m_obuf[0][63:32] : 32'h0);
      check("if_instruction", if_instruction, (m_obuf.size() > 0) ? m_obuf[0][31:0] : 32'h0);
      mem_acc      = imem_req && imem_ready;
      mem_acc_addr = imem_addr;
      if (imem_req && imem_ready) addr_log.push_back(imem_addr);
      if (hi_req && imem_ready)   hi_log.push_back(hi_addr);
      if (if_valid && if_ready && !redirect && !reset) begin
        pc_log.push_back(if_pc);
        ins_log.push_back(if_instruction);
      end
    end
  end

  always @(posedge clk) begin
    bit resp;
    bit req;
    logic [31:0] p;
    req = exp_req() && imem_ready;
    if (imem_rvalid && pending.size() > 0) void'(pending.pop_front());
    if (mem_acc) pending.push_back(mem_acc_addr);
    if (reset) begin
      m_fpc   = 32'h0;
      m_inflight.delete();
      m_obuf.delete();
      m_drop  = 0;
      m_drain = 1'b0;
    end else if (!m_drain) begin
      resp = imem_rvalid && m_inflight.size() > 0;
      if (redirect) begin
        m_drop  = m_inflight.size() - int'(resp);
        m_inflight.delete();
        m_obuf.delete();
        m_fpc   = {redirect_pc[31:2], 2'b00};
        m_drain = (m_drop != 0);
      end else begin
        if (m_obuf.size() > 0 && if_ready) void'(m_obuf.pop_front());
        if (resp) begin
          p = m_inflight.pop_front();
          m_obuf.push_back({p, imem_rdata});
        end
        if (req) begin
          m_inflight.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end else begin
      if (imem_rvalid && m_drop > 0) m_drop--;
      if (redirect) m_fpc = {redirect_pc[31:2], 2'b00};
      if (m_drop == 0) m_drain = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; imem_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    if_ready = 1'b1; resp_en = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    started = 1'b1;
    @(negedge clk); #4;
    check("rst_imem_req", imem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instruction, 0);
    check("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);

    // streaming with an always-ready memory and decoder
    @(negedge clk); reset = 1'b0;
    repeat (12) @(negedge clk);
    #4;
    check("stream_addr0", qat(addr_log, 0), 32'h0000_0000);
    check("stream_addr1", qat(addr_log, 1), 32'h0000_0004);
    check("stream_addr2", qat(addr_log, 2), 32'h0000_0008);
    check("stream_pc0", qat(pc_log, 0), 32'h0000_0000);
    check("stream_pc1", qat(pc_log, 1), 32'h0000_0004);
    check("stream_pc2", qat(pc_log, 2), 32'h0000_0008);
    check("stream_ins0", qat(ins_log, 0), 32'hC0DE_0000);
    check("stream_ins1", qat(ins_log, 1), 32'hC0DE_0024);
    check("wrap_addr0", qat(hi_log, 0), 32'hFFFF_FFF8);
    check("wrap_addr1", qat(hi_log, 1), 32'hFFFF_FFFC);
    check("wrap_addr2", qat(hi_log, 2), 32'h0000_0000);

    // decoder stalled from reset
    @(negedge clk); reset = 1'b1; pending.delete(); if_ready = 1'b0;
    #4; addr_log.delete();
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    check("stall_nreq", addr_log.size(), 2);
    check("stall_req", imem_req, 0);
    check("stall_valid", if_valid, 1);
    check("stall_pc", if_pc, 0);
    check("stall_ins", if_instruction, 32'hC0DE_0000);
    @(negedge clk); if_ready = 1'b1;
    repeat (6) @(negedge clk);

    // redirect with two stale requests in flight
    @(negedge clk); reset = 1'b1; pending.delete(); resp_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #4; pc_log.delete(); ins_log.delete();
    check("redir_pending2", pending.size(), 2);
    @(negedge clk); redirect = 1'b0; resp_en = 1'b1;
    #4;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk); #4; n++;
    end
    check("redir_wait_bound", n < 20, 1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_stale_drained", pending.size(), 0);
    repeat (6) @(negedge clk);
    #4;
    check("redir_pc0", qat(pc_log, 0), 32'h0000_0100);
    check("redir_ins0", qat(ins_log, 0), 32'hC0DE_0900);

    // redirect coinciding with a response, then a second redirect while draining
    @(negedge clk); reset = 1'b1; pending.delete(); resp_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_0200; resp_en = 1'b1;
    @(negedge clk); redirect = 1'b0; resp_en = 1'b0;
    #4; check("drain_req0", imem_req, 0);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_0306;
    @(negedge clk); redirect = 1'b0;
    #4; check("drain_req1", imem_req, 0);
    pc_log.delete(); ins_log.delete();
    @(negedge clk); resp_en = 1'b1;
    #4; check("drain_req2", imem_req, 0);
    @(negedge clk); resp_en = 1'b0;
    #4;
    check("drain_done_req", imem_req, 1);
    check("drain_done_addr", imem_addr, 32'h0000_0304);
    check("drain_pending", pending.size(), 0);
    @(negedge clk); resp_en = 1'b1;
    repeat (8) @(negedge clk);
    #4; check("drain_pc0", qat(pc_log, 0), 32'h0000_0304);

    // reset with two requests in flight; late responses must be ignored
    @(negedge clk); reset = 1'b1; pending.delete(); resp_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #4; addr_log.delete(); pc_log.delete(); ins_log.delete();
    @(negedge clk); reset = 1'b0; imem_ready = 1'b0; resp_en = 1'b1;
    #4; check("late_valid0", if_valid, 0);
    @(negedge clk);
    #4; check("late_valid1", if_valid, 0);
    @(negedge clk); imem_ready = 1'b1;
    #4;
    check("late_valid2", if_valid, 0);
    check("late_req", imem_req, 1);
    check("late_addr", imem_addr, 32'h0000_0000);
    repeat (8) @(negedge clk);
    #4;
    check("late_first_addr", qat(addr_log, 0), 32'h0000_0000);
    check("late_pc0", qat(pc_log, 0), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
